reaction_timer_multi: RTL and testbench

- N-player successor of the single-player reaction timer.
- Start press arms a pseudo-random delay, then lights `led`. The first player to press their stop button freezes a millisecond BCD count, shown on DIGITS seven-segment digits.
- Tracks the best (lowest) time across rounds, shows it on demand, and flags false starts and timeouts.
- Sits between the debounced pushbuttons and the display mux of the board top.

---
 rtl/reaction_timer_pkg.sv | 22 ++
 rtl/bcd_to_sseg.sv | 14 +
 rtl/reaction_timer_multi.sv | 129 ++++++++++++
 tb/tb_reaction_timer_multi.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/reaction_timer_pkg.sv
// rtl/reaction_timer_pkg.sv - shared types and constants for the multi-player reaction timer
package reaction_timer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_RAND = 3'd1,
    TIMING    = 3'd2,
    DONE      = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam logic [7:0]  SSEG_DASH  = 8'hBF;
  localparam logic [7:0]  SSEG_BLANK = 8'hFF;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

  // {dp,g,f,e,d,c,b,a}, active-low, indexed by BCD digit
  localparam logic [7:0] SSEG_TABLE [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

endpackage

// File: rtl/bcd_to_sseg.sv
// rtl/bcd_to_sseg.sv - one BCD digit to active-low seven-segment pattern
module bcd_to_sseg
  import reaction_timer_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SSEG_BLANK;
    if (bcd < 4'd10) seg = SSEG_TABLE[bcd];
  end

endmodule

// File: rtl/reaction_timer_multi.sv
// rtl/reaction_timer_multi.sv - N-player reaction timer with best-time record and false-start detection
module reaction_timer_multi
  import reaction_timer_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int N_PLAYERS    = 2,
  parameter int DIGITS       = 4,
  parameter int DELAY_MIN_MS = 1000,
  parameter int DELAY_BITS   = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [N_PLAYERS-1:0]   stop,
  input  logic                   see_the_record,
  output logic                   led,
  output logic [N_PLAYERS-1:0]   winner,
  output logic                   false_start,
  output logic [8*DIGITS-1:0]    sseg
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW       = $clog2(DELAY_MIN_MS + (1 << DELAY_BITS) + 1);
  localparam int BW       = 4 * DIGITS;
  localparam logic [BW-1:0] ALL_NINES = {DIGITS{4'h9}};

  state_t               state, state_n;
  logic                 entry;
  logic [PW-1:0]        presc;
  logic                 tick;
  logic [15:0]          lfsr;
  logic [DW-1:0]        delay_ms, delay_seed;
  logic [BW-1:0]        cur, rec, cur_inc;
  logic                 inc_carry;
  logic [N_PLAYERS-1:0] stop_act, stop_first;
  logic                 stop_any;

  assign tick       = (presc == PW'(TICK_DIV - 1));
  assign delay_seed = DW'(DELAY_MIN_MS) + DW'(lfsr[DELAY_BITS-1:0]);
  assign stop_act   = ~stop;
  assign stop_any   = |stop_act;
  // isolate lowest set bit so simultaneous presses go to the lowest index
  assign stop_first = stop_act & ((~stop_act) + N_PLAYERS'(1));

  always_comb begin
    cur_inc   = cur;
    inc_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_carry) begin
        if (cur[4*i +: 4] == 4'd9) begin
          cur_inc[4*i +: 4] = 4'd0;
        end else begin
          cur_inc[4*i +: 4] = cur[4*i +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (!start) state_n = WAIT_RAND;
      WAIT_RAND: begin
        if (stop_any) state_n = FAULT;
        else if (tick && delay_ms <= DW'(1)) state_n = TIMING;
      end
      TIMING: begin
        if (stop_any) state_n = DONE;
        else if (tick && cur_inc == ALL_NINES) state_n = DONE;
      end
      DONE:      if (!start) state_n = WAIT_RAND;
      FAULT:     if (!start) state_n = WAIT_RAND;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      entry    <= 1'b0;
      presc    <= '0;
      lfsr     <= LFSR_SEED;
      delay_ms <= '0;
      cur      <= '0;
      rec      <= ALL_NINES;
      winner   <= '0;
    end else begin
      state <= state_n;
      entry <= (state_n != state);
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (state_n != state || tick) presc <= '0;
      else                          presc <= presc + PW'(1);

      case (state)
        IDLE, DONE, FAULT: begin
          if (state_n == WAIT_RAND) begin
            delay_ms <= delay_seed;
            cur      <= '0;
            winner   <= '0;
          end
        end
        WAIT_RAND: if (tick && delay_ms != '0) delay_ms <= delay_ms - DW'(1);
        TIMING: begin
          if (stop_any)  winner <= stop_first;
          else if (tick) cur    <= cur_inc;
        end
        default: ;
      endcase

      // packed BCD orders like binary, so a plain compare is MSD-first
      if (state == DONE && entry && winner != '0 && cur < rec) rec <= cur;
    end
  end

  assign led         = (state == TIMING);
  assign false_start = (state == FAULT);

  genvar g;
  for (g = 0; g < DIGITS; g++) begin : g_digit
    logic [3:0] bcd;
    logic [7:0] seg;
    assign bcd = see_the_record ? rec[4*g +: 4] : cur[4*g +: 4];
    bcd_to_sseg u_dec (.bcd(bcd), .seg(seg));
    assign sseg[8*g +: 8] = (!see_the_record && state == FAULT) ? SSEG_DASH : seg;
  end

endmodule

// File: tb/tb_reaction_timer_multi.sv
// tb/tb_reaction_timer_multi.sv - directed self-checking bench for reaction_timer_multi
module tb_reaction_timer_multi;
  import reaction_timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, see_the_record;
  logic [1:0]  stop, winner;
  logic        led, false_start;
  logic [31:0] sseg;

  int n_cmp = 0;
  int n_bad = 0;

  // one cycle per ms keeps full delays and the 9999 ms timeout short
  reaction_timer_multi #(
    .CLK_HZ(1000), .N_PLAYERS(2), .DIGITS(4), .DELAY_MIN_MS(1000), .DELAY_BITS(11)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .see_the_record(see_the_record), .led(led), .winner(winner),
    .false_start(false_start), .sseg(sseg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mask;
    int          ms;
    logic [1:0]  win;
    logic [31:0] cur_seg;
    logic [31:0] rec_seg;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_pulse();
    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;
  endtask

  task automatic wait_led(output int n);
    n = 0;
    while (!led && n < 4000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_record(input string name, input logic [31:0] exp);
    see_the_record = 1'b1;
    #1 check(name, sseg, exp);
    see_the_record = 1'b0;
    #1;
  endtask

  initial begin
    int n;
    vecs[0] = '{mask: 2'b01, ms: 1234, win: 2'b01, cur_seg: 32'hF9A4B099, rec_seg: 32'hF9A4B099};
    vecs[1] = '{mask: 2'b10, ms: 500,  win: 2'b10, cur_seg: 32'hC092C0C0, rec_seg: 32'hC092C0C0};
    vecs[2] = '{mask: 2'b01, ms: 800,  win: 2'b01, cur_seg: 32'hC080C0C0, rec_seg: 32'hC092C0C0};
    vecs[3] = '{mask: 2'b11, ms: 700,  win: 2'b01, cur_seg: 32'hC0F8C0C0, rec_seg: 32'hC092C0C0};

    reset = 1'b1; start = 1'b1; stop = 2'b11; see_the_record = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_led", 32'(led), 32'd0);
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_false_start", 32'(false_start), 32'd0);
    check("rst_sseg", sseg, 32'hC0C0C0C0);
    check_record("rst_record", 32'h90909090);

    for (int i = 0; i < 4; i++) begin
      start_pulse();
      check($sformatf("r%0d_state_wait", i), 32'(dut.state), 32'(WAIT_RAND));
      check($sformatf("r%0d_wait_led", i), 32'(led), 32'd0);
      check($sformatf("r%0d_wait_sseg", i), sseg, 32'hC0C0C0C0);
      wait_led(n);
      check($sformatf("r%0d_delay_range", i), 32'(n >= 1000 && n <= 3047), 32'd1);
      repeat (vecs[i].ms) @(negedge clk);
      stop = ~vecs[i].mask;
      @(negedge clk) stop = 2'b11;
      check($sformatf("r%0d_state_done", i), 32'(dut.state), 32'(DONE));
      check($sformatf("r%0d_led_off", i), 32'(led), 32'd0);
      check($sformatf("r%0d_winner", i), 32'(winner), 32'(vecs[i].win));
      check($sformatf("r%0d_cur_sseg", i), sseg, vecs[i].cur_seg);
      @(negedge clk);
      check_record($sformatf("r%0d_record", i), vecs[i].rec_seg);
    end

    // false start during the random wait
    start_pulse();
    repeat (5) @(negedge clk);
    check("fs_state_wait", 32'(dut.state), 32'(WAIT_RAND));
    stop = 2'b01;
    @(negedge clk) stop = 2'b11;
    check("fs_flag", 32'(false_start), 32'd1);
    check("fs_state", 32'(dut.state), 32'(FAULT));
    check("fs_sseg_dash", sseg, 32'hBFBFBFBF);
    repeat (20) @(negedge clk);
    check("fs_led_stays_off", 32'(led), 32'd0);
    check_record("fs_record", 32'hC092C0C0);
    start_pulse();
    check("fs_cleared", 32'(false_start), 32'd0);
    check("fs_restart_state", 32'(dut.state), 32'(WAIT_RAND));

    // timeout: no stop pressed
    wait_led(n);
    check("to_delay_range", 32'(n >= 1000 && n <= 3047), 32'd1);
    n = 0;
    while (led && n < 10100) begin
      @(negedge clk);
      n++;
    end
    check("to_duration", 32'(n), 32'd9999);
    check("to_state", 32'(dut.state), 32'(DONE));
    check("to_winner", 32'(winner), 32'd0);
    check("to_sseg", sseg, 32'h90909090);
    repeat (2) @(negedge clk);
    check_record("to_record_kept", 32'hC092C0C0);

    // reset while timing
    start_pulse();
    wait_led(n);
    repeat (10) @(negedge clk);
    check("rt_led_on", 32'(led), 32'd1);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check("rt_led", 32'(led), 32'd0);
    check("rt_state", 32'(dut.state), 32'(IDLE));
    check("rt_winner", 32'(winner), 32'd0);
    check("rt_sseg", sseg, 32'hC0C0C0C0);
    check_record("rt_record", 32'h90909090);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
